// File: rtl/spi_frame_sched.sv
// spi_frame_sched: round-robin scheduler sharing one SPI frame transmitter
// between two requesters. Latches the winner's payload, pulses spi_start,
// waits for spi_done (with timeout), acks the winner, then holds an
// inter-frame gap. Optional statistics counters: define SPI_SCHED_STATS_EN.
module spi_frame_sched #(
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned GAP_CYCLES     = 50,
    parameter int unsigned TIMEOUT_CYCLES = 8192
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    output logic              spi_start,
    output logic [DATA_W-1:0] spi_data,
    input  logic              spi_done,
    output logic              busy,
    output logic              grant_id,
    output logic              err,
    output logic [15:0]       frame_count,
    output logic [7:0]        err_count
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_GAP
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [DATA_W-1:0] spi_data_d;
    logic              grant_id_d;
    logic              ack0_d, ack1_d, spi_start_d, busy_d, err_d;
    logic              winner;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            tmo_q        <= '0;
            gap_q        <= '0;
            spi_data     <= '0;
            grant_id     <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            spi_start    <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
            spi_data     <= spi_data_d;
            grant_id     <= grant_id_d;
            ack0         <= ack0_d;
            ack1         <= ack1_d;
            spi_start    <= spi_start_d;
            busy         <= busy_d;
            err          <= err_d;
        end
    end

    // Next-state, arbitration and next-output logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        tmo_d        = tmo_q;
        gap_d        = gap_q;
        spi_data_d   = spi_data;
        grant_id_d   = grant_id;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        spi_start_d  = 1'b0;
        err_d        = 1'b0;
        // Tie goes to the requester that did not win last time
        winner       = (req0 && req1) ? ~last_grant_q : req1;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d      = S_START;
                    spi_data_d   = winner ? data1 : data0;
                    grant_id_d   = winner;
                    last_grant_d = winner;
                    spi_start_d  = 1'b1;
                end
            end
            S_START: begin
                state_d = S_WAIT_DONE;
                tmo_d   = '0;
            end
            S_WAIT_DONE: begin
                // Completion takes priority over a coincident timeout
                if (spi_done) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                    ack0_d  = ~grant_id;
                    ack1_d  = grant_id;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

`ifdef SPI_SCHED_STATS_EN
    // Completed-frame counter (wrapping) and timeout counter (saturating)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            if (ack0_d || ack1_d) begin
                frame_count <= frame_count + 16'd1;
            end
            if (err_d && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`else
    assign frame_count = '0;
    assign err_count   = '0;
`endif

endmodule

// File: tb/tb_spi_frame_sched.sv
// Scoreboard bench for spi_frame_sched: stimulus pushes expected events
// (start/ack/err/busy-fall with cycle stamps), a negedge monitor pops and compares.
module tb_spi_frame_sched;

    localparam int unsigned DW = 64;
    localparam int unsigned G  = 4;
    localparam int unsigned T  = 128;

    localparam logic [DW-1:0] D0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [DW-1:0] D1 = 64'hDEAD_BEEF_0000_0001;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, spi_done = 1'b0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic          ack0, ack1, spi_start, busy, grant_id, err;
    logic [DW-1:0] spi_data;
    logic [15:0]   frame_count;
    logic [7:0]    err_count;

    spi_frame_sched #(
        .DATA_W(DW),
        .GAP_CYCLES(G),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req0(req0),
        .data0(data0),
        .ack0(ack0),
        .req1(req1),
        .data1(data1),
        .ack1(ack1),
        .spi_start(spi_start),
        .spi_data(spi_data),
        .spi_done(spi_done),
        .busy(busy),
        .grant_id(grant_id),
        .err(err),
        .frame_count(frame_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_START, EV_ACK, EV_ERR, EV_IDLE} ev_e;
    typedef struct {
        ev_e           kind;
        logic          id;
        logic [DW-1:0] data;
        int unsigned   at;
    } ev_t;

    ev_t         sb[$];
    int          total = 0;
    int          bad = 0;
    int unsigned exp_frames = 0;
    int unsigned exp_errs = 0;
    logic        busy_prev = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input ev_e k, input logic id, input logic [DW-1:0] d, input int unsigned at);
        ev_t e;
        e.kind = k;
        e.id   = id;
        e.data = d;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic observe(input ev_e k, input logic id, input logic [DW-1:0] d);
        ev_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event got kind=%s id=%0d cyc=%0d expected none", k.name(), id, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.at != cyc || (k != EV_IDLE && (e.id !== id || e.data !== d))) begin
                bad++;
                $display("FAIL event got kind=%s id=%0d data=%h cyc=%0d expected kind=%s id=%0d data=%h cyc=%0d",
                         k.name(), id, d, cyc, e.kind.name(), e.id, e.data, e.at);
            end
        end
    endtask

    // Monitor: turns DUT output activity into events for the scoreboard
    always @(negedge clk) begin
        if (spi_start === 1'b1) observe(EV_START, grant_id, spi_data);
        if (ack0 === 1'b1 || ack1 === 1'b1) begin
            total++;
            if (ack0 === 1'b1 && ack1 === 1'b1) begin
                bad++;
                $display("FAIL ack_overlap got ack0=1 ack1=1 expected at most one high");
            end
            observe(EV_ACK, ack1, spi_data);
        end
        if (err === 1'b1) observe(EV_ERR, grant_id, spi_data);
        if (busy_prev === 1'b1 && busy === 1'b0) observe(EV_IDLE, 1'b0, '0);
        busy_prev = busy;
    end

    function automatic logic [15:0] exp_fc();
`ifdef SPI_SCHED_STATS_EN
        return 16'(exp_frames);
`else
        return 16'd0;
`endif
    endfunction

    function automatic logic [7:0] exp_ec();
`ifdef SPI_SCHED_STATS_EN
        return (exp_errs > 255) ? 8'hFF : 8'(exp_errs);
`else
        return 8'd0;
`endif
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_spi_start", 64'(spi_start), 64'd0);
        chk("rst_acks", 64'({ack1, ack0}), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_spi_data", spi_data, 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        rst_n = 1'b1;
        exp_frames = 0;
        exp_errs = 0;
    endtask

    // Waits (bounded) until spi_start is visible; returns that cycle
    task automatic wait_start(output int unsigned s);
        s = 0;
        for (int i = 0; i < 400; i++) begin
            if (spi_start === 1'b1) begin
                s = cyc;
                return;
            end
            step();
        end
        total++;
        bad++;
        $display("FAIL wait_start got no spi_start expected one within 400 cycles");
    endtask

    // Pulses spi_done after k cycles and queues the resulting ack and busy fall
    task automatic done_ack(input int unsigned k, input logic id, input logic [DW-1:0] d, output int unsigned a);
        a = cyc + k + 1;
        push(EV_ACK, id, d, a);
        push(EV_IDLE, 1'b0, '0, a + G + 1);
        exp_frames++;
        repeat (k) step();
        spi_done = 1'b1;
        step();
        spi_done = 1'b0;
    endtask

    int unsigned s, a;

    initial begin
        // Single request, late data change, stray spi_done in GAP and IDLE
        do_reset();
        data0 = D0;
        req0 = 1'b1;
        push(EV_START, 1'b0, D0, cyc + 1);
        step();
        req0 = 1'b0;
        wait_start(s);
        step();
        data0 = 64'hFFFF_0000_FFFF_0000;
        done_ack(98, 1'b0, D0, a);
        step();
        spi_done = 1'b1;
        step();
        spi_done = 1'b0;
        repeat (G + 2) step();
        spi_done = 1'b1;
        step();
        spi_done = 1'b0;
        repeat (3) step();
        chk("single_frame_count", 64'(frame_count), 64'(exp_fc()));

        // Continuous tie: grants alternate 0,1,0,1
        do_reset();
        data0 = D0;
        data1 = D1;
        req0 = 1'b1;
        req1 = 1'b1;
        push(EV_START, 1'b0, D0, cyc + 1);
        for (int k = 0; k < 4; k++) begin
            wait_start(s);
            done_ack(5, k[0], k[0] ? D1 : D0, a);
            if (k < 3) push(EV_START, ~k[0], k[0] ? D0 : D1, a + G + 2);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (G + 3) step();
        chk("tie_frame_count", 64'(frame_count), 64'(exp_fc()));

        // Timeout: no spi_done
        do_reset();
        data1 = D1;
        req1 = 1'b1;
        push(EV_START, 1'b1, D1, cyc + 1);
        step();
        req1 = 1'b0;
        wait_start(s);
        push(EV_ERR, 1'b1, D1, s + T + 1);
        push(EV_IDLE, 1'b0, '0, s + T + G + 2);
        exp_errs++;
        repeat (T + G + 5) step();
        chk("timeout_err_count", 64'(err_count), 64'(exp_ec()));
        chk("timeout_frame_count", 64'(frame_count), 64'(exp_fc()));

        // Done coincides with last timeout cycle: ack wins, no err
        do_reset();
        req0 = 1'b1;
        push(EV_START, 1'b0, D0, cyc + 1);
        step();
        req0 = 1'b0;
        wait_start(s);
        done_ack(T, 1'b0, D0, a);
        repeat (G + 3) step();
        chk("collide_err_count", 64'(err_count), 64'(exp_ec()));

        // Mid-frame reset, then tie must go to requester 0 again
        do_reset();
        req0 = 1'b1;
        push(EV_START, 1'b0, D0, cyc + 1);
        step();
        req0 = 1'b0;
        wait_start(s);
        repeat (5) step();
        rst_n = 1'b0;
        push(EV_IDLE, 1'b0, '0, cyc + 1);
        step();
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_spi_data", spi_data, 64'd0);
        chk("midrst_grant_id", 64'(grant_id), 64'd0);
        step();
        rst_n = 1'b1;
        exp_frames = 0;
        exp_errs = 0;
        req0 = 1'b1;
        req1 = 1'b1;
        push(EV_START, 1'b0, D0, cyc + 1);
        step();
        req0 = 1'b0;
        req1 = 1'b0;
        wait_start(s);
        done_ack(3, 1'b0, D0, a);
        repeat (G + 3) step();

        // Request held through ack: re-granted after the gap
        do_reset();
        req0 = 1'b1;
        push(EV_START, 1'b0, D0, cyc + 1);
        wait_start(s);
        done_ack(3, 1'b0, D0, a);
        push(EV_START, 1'b0, D0, a + G + 2);
        wait_start(s);
        req0 = 1'b0;
        done_ack(3, 1'b0, D0, a);
        repeat (G + 3) step();
        chk("held_frame_count", 64'(frame_count), 64'(exp_fc()));

        repeat (5) step();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_frame_sched.md
Name: spi_frame_sched

Overview:
Scheduler that shares the 64-bit SPI frame transmitter between two requesters, e.g. the AES plaintext/key source and the ciphertext capture path. Round-robin arbitration selects one requester and latches its 64-bit word. The block pulses the transmitter start, waits for frame completion (with a timeout), acknowledges the winner, then enforces an inter-frame gap. It sits between the AES datapath and the SPI shifter, replacing button-triggered framing with request-driven framing.

Parameters:
DATA_W, 64, frame payload width in bits
GAP_CYCLES, 50, idle clk cycles forced between frames; 0 = no gap
TIMEOUT_CYCLES, 8192, max cycles in WAIT_DONE before abort; must be >= 2

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
req0  in  1  requester 0 frame request, level, held until ack0
data0  in  DATA_W  requester 0 payload, stable while req0 high
ack0  out  1  one-cycle pulse: requester 0 frame sent
req1  in  1  requester 1 frame request, level, held until ack1
data1  in  DATA_W  requester 1 payload
ack1  out  1  one-cycle pulse: requester 1 frame sent
spi_start  out  1  one-cycle pulse to transmitter: begin frame
spi_data  out  DATA_W  latched payload, stable from START until state returns to IDLE
spi_done  in  1  one-cycle pulse from transmitter: frame complete (ss released)
busy  out  1  high in every state except IDLE
grant_id  out  1  requester owning current or last frame
err  out  1  one-cycle pulse on timeout abort
frame_count  out  16  completed-frame counter (see Optional Feature)
err_count  out  8  timeout counter (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; ack0, ack1, spi_start, busy, err=0; spi_data=0; grant_id=0; last_grant=1 so req0 wins first tie; gap/timeout counters=0. Reset mid-frame aborts without ack. The transmitter shares rst_n.
- States: IDLE, START, WAIT_DONE, GAP.
- IDLE: req sampled every cycle. Only one req high: grant it. Both high: grant the requester != last_grant. On grant, next cycle: state=START, spi_data=winner's data, grant_id=winner, last_grant=winner.
- START: one cycle; spi_start=1; next state=WAIT_DONE; timeout counter cleared.
- WAIT_DONE: timeout counter increments each cycle.
  - On spi_done=1: next cycle ack for grant_id pulses 1 for exactly one cycle; state=GAP.
  - Else if counter reaches TIMEOUT_CYCLES-1: next cycle err=1 for one cycle, no ack; state=GAP.
  - spi_done and timeout in the same cycle: done wins, no err.
- GAP: counts GAP_CYCLES cycles, then IDLE. GAP_CYCLES=0: GAP lasts one cycle.
- spi_done outside WAIT_DONE: ignored.
- req changes outside IDLE: ignored. Data is latched once in IDLE->START; later data changes do not affect spi_data.
- Requester must drop req the cycle after ack. If req is still high in IDLE, it is treated as a new request.
- Latency: req rising in IDLE -> spi_start 1 cycle later. spi_done -> ack 1 cycle later. Ack -> earliest next spi_start = GAP_CYCLES+2 cycles.
- ack0 and ack1 are never high together. spi_start is never high outside START.

Optional Feature:
Macro SPI_SCHED_STATS_EN.
- Defined:
  - frame_count increments by 1 on every ack pulse and wraps 0xFFFF->0.
  - err_count increments on every err pulse and saturates at 0xFF.
  - Both reset to 0.
- Not defined: frame_count and err_count are tied to constant 0 and no counter registers are synthesized. All other behaviour is identical.

Test Plan:
- Single request: req0=1, data0=64'h0123_4567_89AB_CDEF in IDLE -> spi_start pulse 1 cycle later; spi_data=0x0123456789ABCDEF; spi_done after 100 cycles -> ack0 1 cycle later; busy low after GAP_CYCLES+1 more cycles.
- Tie/fairness: req0=req1=1 continuously after reset, data1=64'hDEAD_BEEF_0000_0001 -> grant order 0,1,0,1 over 4 frames; each ack single-cycle; ack0/ack1 never overlap.
- Timeout: req1=1, no spi_done -> err pulse exactly TIMEOUT_CYCLES cycles after START exit; no ack1; err_count=1 with SPI_SCHED_STATS_EN.
- Done/timeout collision: spi_done asserted on the cycle the counter hits TIMEOUT_CYCLES-1 -> ack issued, err stays 0.
- Mid-frame reset: rst_n=0 during WAIT_DONE -> next posedge state IDLE, busy=0, spi_data=0, no ack; a subsequent req0 with req1 tie grants req0.
- Stray/late inputs: spi_done pulsed in IDLE and GAP -> no ack. data0 changed during WAIT_DONE -> spi_data unchanged. With GAP_CYCLES=0, back-to-back req0 -> next spi_start 2 cycles after ack0.
